// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
//   Bundles the IF/ID-side inputs, the write-back port and the ID/EX-side
//   outputs of the decode stage.
//   master : the producer of IF/ID + write-back, the consumer of ID/EX.
//   slave  : the decode stage itself.
//   Inputs to the stage : InPC, InInst, Flush, WBEn, WBAddr, WBData
//   Outputs of the stage: Stall (combinational), PC, RD1, RD2, Imm, Rs, Rt,
//                         Dest, Funct, ALUOp, RegWrite, MemRead, MemWrite,
//                         MemtoReg, ALUSrc, Branch, Jump, Valid
interface id_ex_stage_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] InPC;
   logic [31:0]     InInst;
   logic            Flush;
   logic            WBEn;
   logic [4:0]      WBAddr;
   logic [XLEN-1:0] WBData;

   logic            Stall;
   logic [XLEN-1:0] PC;
   logic [XLEN-1:0] RD1;
   logic [XLEN-1:0] RD2;
   logic [XLEN-1:0] Imm;
   logic [4:0]      Rs;
   logic [4:0]      Rt;
   logic [4:0]      Dest;
   logic [5:0]      Funct;
   logic [1:0]      ALUOp;
   logic            RegWrite;
   logic            MemRead;
   logic            MemWrite;
   logic            MemtoReg;
   logic            ALUSrc;
   logic            Branch;
   logic            Jump;
   logic            Valid;

   modport master (
      output InPC, InInst, Flush, WBEn, WBAddr, WBData,
      input  Stall, PC, RD1, RD2, Imm, Rs, Rt, Dest, Funct, ALUOp,
             RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, Valid
   );

   modport slave (
      input  InPC, InInst, Flush, WBEn, WBAddr, WBData,
      output Stall, PC, RD1, RD2, Imm, Rs, Rt, Dest, Funct, ALUOp,
             RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, Valid
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Instruction decode + register file read (with write-back bypass) + ID/EX
//   pipeline register. Raises Stall for one cycle on a load-use hazard and
//   inserts a bubble on Stall or Flush.
//   Ports:
//     CLK   : clock, all state on rising edge
//     RSTB  : asynchronous active-low reset (clears ID/EX and register file)
//     bus   : id_ex_stage_if.slave -- IF/ID inputs, write-back port,
//             combinational Stall and the registered ID/EX outputs
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input logic          CLK,
   input logic          RSTB,
   id_ex_stage_if.slave bus
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   // instruction fields
   logic [5:0]  op;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;

   assign op    = bus.InInst[31:26];
   assign rs    = bus.InInst[25:21];
   assign rt    = bus.InInst[20:16];
   assign rd    = bus.InInst[15:11];
   assign imm16 = bus.InInst[15:0];

   // decode
   logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_memto_reg;
   logic       dec_alu_src, dec_branch, dec_jump, uses_rt;
   logic [1:0] dec_alu_op;
   logic [4:0] dec_dest;

   always_comb begin
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_memto_reg = 1'b0;
      dec_alu_src   = 1'b0;
      dec_branch    = 1'b0;
      dec_jump      = 1'b0;
      dec_alu_op    = 2'b00;
      dec_dest      = 5'd0;
      uses_rt       = 1'b0;
      case (op)
         OP_RTYPE: begin
            dec_reg_write = 1'b1;
            dec_alu_op    = 2'b10;
            dec_dest      = rd;
            uses_rt       = 1'b1;
         end
         OP_ADDI: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_dest      = rt;
         end
         OP_LW: begin
            dec_reg_write = 1'b1;
            dec_mem_read  = 1'b1;
            dec_memto_reg = 1'b1;
            dec_alu_src   = 1'b1;
            dec_dest      = rt;
         end
         OP_SW: begin
            dec_mem_write = 1'b1;
            dec_alu_src   = 1'b1;
            uses_rt       = 1'b1;
         end
         OP_BEQ: begin
            dec_branch    = 1'b1;
            dec_alu_op    = 2'b01;
            uses_rt       = 1'b1;
         end
         OP_J: begin
            dec_jump      = 1'b1;
         end
         default: ; // unknown opcode runs as a NOP with Valid=1
      endcase
   end

   // register file; r0 is never written so it always reads 0
   logic [XLEN-1:0] regs [NREG];
   logic            wb_wr;

   assign wb_wr = bus.WBEn && (bus.WBAddr != 5'd0);

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wb_wr) begin
         regs[bus.WBAddr] <= bus.WBData;
      end
   end

   // write-back data is forwarded so a write is visible in the same cycle
   logic [XLEN-1:0] rd1_val, rd2_val, imm_val;

   always_comb begin
      rd1_val = regs[rs];
      if (rs == 5'd0)                     rd1_val = '0;
      else if (wb_wr && bus.WBAddr == rs) rd1_val = bus.WBData;
      rd2_val = regs[rt];
      if (rt == 5'd0)                     rd2_val = '0;
      else if (wb_wr && bus.WBAddr == rt) rd2_val = bus.WBData;
   end

   assign imm_val = {{(XLEN-16){imm16[15]}}, imm16};

   // load-use hazard against the load now sitting in ID/EX; a flush kills
   // the dependent instruction anyway, so it must not hold upstream
   logic bubble;

   assign bus.Stall = bus.Valid & bus.MemRead & (bus.Dest != 5'd0) &
                      ((bus.Dest == rs) | (uses_rt & (bus.Dest == rt))) &
                      ~bus.Flush;
   assign bubble    = bus.Flush | bus.Stall;

   // ID/EX register
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB || bubble) begin
         bus.PC       <= '0;
         bus.RD1      <= '0;
         bus.RD2      <= '0;
         bus.Imm      <= '0;
         bus.Rs       <= '0;
         bus.Rt       <= '0;
         bus.Dest     <= '0;
         bus.Funct    <= '0;
         bus.ALUOp    <= '0;
         bus.RegWrite <= 1'b0;
         bus.MemRead  <= 1'b0;
         bus.MemWrite <= 1'b0;
         bus.MemtoReg <= 1'b0;
         bus.ALUSrc   <= 1'b0;
         bus.Branch   <= 1'b0;
         bus.Jump     <= 1'b0;
         bus.Valid    <= 1'b0;
      end else begin
         bus.PC       <= bus.InPC;
         bus.RD1      <= rd1_val;
         bus.RD2      <= rd2_val;
         bus.Imm      <= imm_val;
         bus.Rs       <= rs;
         bus.Rt       <= rt;
         bus.Dest     <= dec_dest;
         bus.Funct    <= bus.InInst[5:0];
         bus.ALUOp    <= dec_alu_op;
         bus.RegWrite <= dec_reg_write;
         bus.MemRead  <= dec_mem_read;
         bus.MemWrite <= dec_mem_write;
         bus.MemtoReg <= dec_memto_reg;
         bus.ALUSrc   <= dec_alu_src;
         bus.Branch   <= dec_branch;
         bus.Jump     <= dec_jump;
         bus.Valid    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Vector table of {inputs, expected ID/EX outputs}; each vector is driven,
//   its expected record queued, and the record popped and compared one edge
//   later. Reset-mid-stall is a hand-written sequence.
module tb_id_ex_stage;
   logic CLK  = 1'b0;
   logic RSTB = 1'b0;
   always #5 CLK = ~CLK;

   id_ex_stage_if bus ();
   id_ex_stage dut (.CLK(CLK), .RSTB(RSTB), .bus(bus));

   // ctl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump}
   localparam logic [6:0] C_R    = 7'b1000000;
   localparam logic [6:0] C_ADDI = 7'b1000100;
   localparam logic [6:0] C_LW   = 7'b1101100;
   localparam logic [6:0] C_SW   = 7'b0010100;
   localparam logic [6:0] C_BEQ  = 7'b0000010;
   localparam logic [6:0] C_J    = 7'b0000001;
   localparam logic [6:0] C_NONE = 7'b0000000;

   typedef struct packed {
      logic [31:0] inst;
      logic        flush;
      logic        wben;
      logic [4:0]  wbaddr;
      logic [31:0] wbdata;
      logic        stall;
      logic        valid;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic [1:0]  aluop;
      logic [6:0]  ctl;
      logic [31:0] pc;
   } vec_t;

   vec_t        tbl[$];
   vec_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] pc_cnt   = 32'h0000_1000;

   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic vec_t v(input logic [31:0] inst, input logic flush, wben,
                              input logic [4:0] wbaddr, input logic [31:0] wbdata,
                              input logic stall, valid, input logic [31:0] rd1, rd2, imm,
                              input logic [4:0] rs, rt, dest, input logic [1:0] aluop,
                              input logic [6:0] ctl);
      vec_t r;
      r.inst = inst; r.flush = flush; r.wben = wben; r.wbaddr = wbaddr; r.wbdata = wbdata;
      r.stall = stall; r.valid = valid; r.rd1 = rd1; r.rd2 = rd2; r.imm = imm;
      r.rs = rs; r.rt = rt; r.dest = dest; r.aluop = aluop; r.ctl = ctl; r.pc = '0;
      return r;
   endfunction

   // bubble: everything cleared in ID/EX
   function automatic vec_t bub(input logic [31:0] inst, input logic flush, input logic stall);
      return v(inst, flush, 1'b0, 5'd0, 32'd0, stall, 1'b0, 0, 0, 0, 0, 0, 0, 2'b00, C_NONE);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_stall"}, 32'(bus.Stall), 32'd0);
      chk({tag, "_valid"}, 32'(bus.Valid), 32'd0);
      chk({tag, "_ctl"}, 32'({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.MemtoReg,
                              bus.ALUSrc, bus.Branch, bus.Jump}), 32'd0);
      chk({tag, "_data"}, bus.PC | bus.RD1 | bus.RD2 | bus.Imm, 32'd0);
      chk({tag, "_idx"}, 32'({bus.Rs, bus.Rt, bus.Dest, bus.Funct, bus.ALUOp}), 32'd0);
   endtask

   task automatic step(input vec_t t);
      vec_t e;
      t.pc = pc_cnt;
      pc_cnt += 32'd4;
      bus.InPC   = t.pc;
      bus.InInst = t.inst;
      bus.Flush  = t.flush;
      bus.WBEn   = t.wben;
      bus.WBAddr = t.wbaddr;
      bus.WBData = t.wbdata;
      @(negedge CLK);
      chk("stall", 32'(bus.Stall), 32'(t.stall));
      sb_q.push_back(t);
      @(posedge CLK);
      #1;
      if (sb_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL scoreboard_empty: got 0 entries want 1");
      end else begin
         e = sb_q.pop_front();
         chk("valid", 32'(bus.Valid), 32'(e.valid));
         chk("ctl", 32'({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.MemtoReg,
                         bus.ALUSrc, bus.Branch, bus.Jump}), 32'(e.ctl));
         chk("aluop", 32'(bus.ALUOp), 32'(e.aluop));
         chk("dest", 32'(bus.Dest), 32'(e.dest));
         chk("rs", 32'(bus.Rs), 32'(e.rs));
         chk("rt", 32'(bus.Rt), 32'(e.rt));
         chk("rd1", bus.RD1, e.rd1);
         chk("rd2", bus.RD2, e.rd2);
         chk("imm", bus.Imm, e.imm);
         chk("pc", bus.PC, e.valid ? e.pc : 32'd0);
         chk("funct", 32'(bus.Funct), e.valid ? 32'(e.inst[5:0]) : 32'd0);
      end
   endtask

   initial begin
      logic [31:0] add_r1_r5_r0, add_r3_r2_r2, lw_r2_0_r0, sw_r3_0_r5;

      add_r1_r5_r0 = rtype(5'd5, 5'd0, 5'd1, 6'h20);
      add_r3_r2_r2 = rtype(5'd2, 5'd2, 5'd3, 6'h20);
      lw_r2_0_r0   = itype(6'h23, 5'd0, 5'd2, 16'h0000);
      sw_r3_0_r5   = itype(6'h2B, 5'd5, 5'd3, 16'h0000);

      bus.InPC = '0; bus.InInst = '0; bus.Flush = 1'b0;
      bus.WBEn = 1'b0; bus.WBAddr = '0; bus.WBData = '0;

      #12;
      chk_idle("reset");
      RSTB = 1'b1;

      // reset mid-stall: r5 written, a load in ID/EX and a dependent ADD waiting
      step(v(add_r1_r5_r0, 0, 1, 5'd5, 32'h1234, 0, 1, 32'h1234, 0, 32'h0820, 5, 0, 1, 2'b10, C_R));
      step(v(itype(6'h23, 5'd5, 5'd2, 16'h0), 0, 0, 0, 0, 0, 1, 32'h1234, 0, 0, 5, 2, 2, 2'b00, C_LW));
      bus.InInst = add_r3_r2_r2;
      bus.WBEn   = 1'b0;
      #1;
      chk("pre_reset_stall", 32'(bus.Stall), 32'd1);
      RSTB = 1'b0;
      #1;
      chk_idle("midrun_reset");
      #1;
      RSTB = 1'b1;
      // r5 was cleared by reset
      step(v(add_r1_r5_r0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0820, 5, 0, 1, 2'b10, C_R));

      // bypass: r3 written while ADD r4,r3,r3 decodes
      tbl.push_back(v(rtype(5'd3, 5'd3, 5'd4, 6'h20), 0, 1, 5'd3, 32'hDEADBEEF, 0, 1,
                      32'hDEADBEEF, 32'hDEADBEEF, 32'h2020, 3, 3, 4, 2'b10, C_R));
      // load-use on rs/rt: LW r2,8(r1) (r1 via bypass), ADD r3,r2,r2 stalls once
      tbl.push_back(v(itype(6'h23, 5'd1, 5'd2, 16'd8), 0, 1, 5'd1, 32'h100, 0, 1,
                      32'h100, 0, 32'd8, 1, 2, 2, 2'b00, C_LW));
      tbl.push_back(bub(add_r3_r2_r2, 0, 1));
      tbl.push_back(v(add_r3_r2_r2, 0, 1, 5'd2, 32'hCAFE0000, 0, 1,
                      32'hCAFE0000, 32'hCAFE0000, 32'h1820, 2, 2, 3, 2'b10, C_R));
      // LW r2 then ADDI r5,r2,1: rs match stalls
      tbl.push_back(v(lw_r2_0_r0, 0, 0, 0, 0, 0, 1, 0, 32'hCAFE0000, 0, 0, 2, 2, 2'b00, C_LW));
      tbl.push_back(bub(itype(6'h08, 5'd2, 5'd5, 16'd1), 0, 1));
      // LW r2 then ADDI r2,r0,1: rt unused, no stall
      tbl.push_back(v(lw_r2_0_r0, 0, 0, 0, 0, 0, 1, 0, 32'hCAFE0000, 0, 0, 2, 2, 2'b00, C_LW));
      tbl.push_back(v(itype(6'h08, 5'd0, 5'd2, 16'd1), 0, 0, 0, 0, 0, 1,
                      0, 32'hCAFE0000, 32'd1, 0, 2, 2, 2'b00, C_ADDI));
      // load-use pair with Flush the same cycle: no stall, bubble
      tbl.push_back(v(lw_r2_0_r0, 0, 0, 0, 0, 0, 1, 0, 32'hCAFE0000, 0, 0, 2, 2, 2'b00, C_LW));
      tbl.push_back(bub(add_r3_r2_r2, 1, 0));
      // SW r7,-4(r6) with r6 bypassed
      tbl.push_back(v(itype(6'h2B, 5'd6, 5'd7, 16'hFFFC), 0, 1, 5'd6, 32'h40, 0, 1,
                      32'h40, 0, 32'hFFFFFFFC, 6, 7, 0, 2'b00, C_SW));
      // unknown opcode 0x3F; write to r0 ignored
      tbl.push_back(v(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 0, 1, 5'd0, 32'hFFFF, 0, 1,
                      32'h100, 32'hCAFE0000, 32'h1234, 1, 2, 0, 2'b00, C_NONE));
      // r0 reads 0 even with a concurrent write to r0
      tbl.push_back(v(rtype(5'd0, 5'd0, 5'd1, 6'h20), 0, 1, 5'd0, 32'hFFFF, 0, 1,
                      0, 0, 32'h0820, 0, 0, 1, 2'b10, C_R));
      // BEQ r1,r3,-2
      tbl.push_back(v(itype(6'h04, 5'd1, 5'd3, 16'hFFFE), 0, 0, 0, 0, 0, 1,
                      32'h100, 32'hDEADBEEF, 32'hFFFFFFFE, 1, 3, 0, 2'b01, C_BEQ));
      // J
      tbl.push_back(v({6'h02, 26'h0000010}, 0, 0, 0, 0, 0, 1,
                      0, 0, 32'h10, 0, 0, 0, 2'b00, C_J));
      // LW r3 then SW r3,0(r5): rt-only match stalls for a store
      tbl.push_back(v(itype(6'h23, 5'd1, 5'd3, 16'd4), 0, 0, 0, 0, 0, 1,
                      32'h100, 32'hDEADBEEF, 32'd4, 1, 3, 3, 2'b00, C_LW));
      tbl.push_back(bub(sw_r3_0_r5, 0, 1));
      tbl.push_back(v(sw_r3_0_r5, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 5, 3, 0, 2'b00, C_SW));

      foreach (tbl[i]) step(tbl[i]);

      if (sb_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Instruction-decode stage plus ID/EX pipeline register, directly downstream of the IF/ID register.
- Decodes the IF/ID instruction and reads the 32x32 register file, with same-cycle write-back bypass.
- Registers operands and control for EX.
- Detects load-use hazards and produces the stall that holds PC and IF/ID; accepts a flush from branch resolution.

Parameters:
- XLEN, 32, datapath width
- NREG, 32, register-file depth (address width 5)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RSTB  input  1  asynchronous active-low reset
- InPC  input  32  PC from IF/ID
- InInst  input  32  instruction from IF/ID
- Flush  input  1  kill the instruction entering ID/EX (taken branch/jump)
- WBEn  input  1  write-back enable
- WBAddr  input  5  write-back register index
- WBData  input  32  write-back data
- Stall  output  1  combinational; hold PC and IF/ID this cycle
- PC  output  32  registered InPC
- RD1, RD2  output  32  registered rs/rt operands
- Imm  output  32  registered sign-extended imm16
- Rs, Rt, Dest  output  5  registered source and destination indices
- Funct  output  6  registered InInst[5:0]
- ALUOp  output  2  00 add, 01 sub, 10 use Funct
- RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump  output  1 each  registered controls
- Valid  output  1  ID/EX holds a real instruction

Behaviour:
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]. Imm = {{16{imm[15]}}, imm}.
- Decode table. Every control not listed below is 0.
  - op 0x00 R-type: RegWrite, ALUOp=10, Dest=rd.
  - 0x08 ADDI: RegWrite, ALUSrc, ALUOp=00, Dest=rt.
  - 0x23 LW: RegWrite, MemRead, MemtoReg, ALUSrc, ALUOp=00, Dest=rt.
  - 0x2B SW: MemWrite, ALUSrc, ALUOp=00, Dest=0.
  - 0x04 BEQ: Branch, ALUOp=01, Dest=0.
  - 0x02 J: Jump, Dest=0.
  - Any other opcode: all controls 0, Valid=1 (executes as NOP).
- Instruction word 0x00000000 decodes as R-type with Dest=0. RegWrite to r0 is harmless.
- Register file:
  - Written on the rising edge when WBEn=1 and WBAddr!=0. Writes to r0 are ignored; r0 always reads 0.
  - Combinational read with bypass: if WBEn=1, WBAddr!=0 and WBAddr==rs, the read returns WBData (same for rt).
- uses_rt = 1 for R-type, SW, BEQ; 0 otherwise.
- Stall = Valid & MemRead & (Dest!=0) & ((Dest==rs) | (uses_rt & (Dest==rt))) & ~Flush.
- Each rising edge:
  - If Flush or Stall: load a bubble — all controls 0, Valid=0, Dest=0. Data outputs are don't-care; the implementation clears them to 0.
  - Otherwise: load the decoded instruction with Valid=1.
- Stall lasts exactly one cycle per load-use pair. The bubble clears MemRead, which drops Stall, and the held instruction then reads the loaded value through WB bypass or the register file.
- Flush has priority over Stall. During Flush, Stall=0 so upstream advances.
- Latency: decode to ID/EX outputs = 1 cycle. Register write visible to the next read = same cycle, via bypass.
- Reset (RSTB=0, asynchronous, at any time including mid-stall):
  - All outputs 0, Valid=0, Stall=0.
  - All 32 registers cleared to 0.
  - Normal operation resumes on the first rising edge after RSTB=1.

Test Plan:
- Reset mid-run: write r5=0x1234, then pulse RSTB low between edges. Required: all outputs 0 immediately; ADD r1,r5,r0 then gives RD1=0.
- Bypass: WBEn=1, WBAddr=3, WBData=0xDEADBEEF in the same cycle as InInst=ADD r4,r3,r3. Required next edge: RD1=RD2=0xDEADBEEF, Dest=4, RegWrite=1, ALUOp=10.
- Load-use: LW r2,8(r1) followed by ADD r3,r2,r2.
  - Required: Stall=1 for exactly one cycle; ID/EX holds a bubble (Valid=0, RegWrite=0).
  - Next cycle: Stall=0 and the ADD enters with Rs=Rt=2.
- No false stall: LW r2 followed by ADDI r5,r2... is a stall (rs match). LW r2 followed by ADDI r2,r0,1 gives Stall=0 (rt unused).
- Flush with stall: force a load-use pair and assert Flush the same cycle. Required: Stall=0, bubble loaded, Valid=0.
- Decode sweep: SW r7,-4(r6) gives Imm=0xFFFFFFFC, MemWrite=1, ALUSrc=1, Dest=0. Opcode 0x3F gives all controls 0, Valid=1. Write to r0 with 0xFFFF then read r0 gives 0.
